// File: rtl/fdivsqrt_result_buf_if.sv
// Result bundle from the divide/sqrt M stage and the head-of-queue handshake
// toward the rounder / integer writeback.
interface fdivsqrt_result_buf_if #(
    parameter int NE      = 11,
    parameter int DIVb    = 64,
    parameter int XLEN    = 64,
    parameter int FMTBITS = 2
);
    logic               DoneM;
    logic               FlushM;
    logic               ClearQ;
    logic               IntDivM;
    logic [FMTBITS-1:0] FmtM;
    logic [4:0]         RdM;
    logic [NE+1:0]      UeM;
    logic [DIVb:0]      UmM;
    logic               DivStickyM;
    logic [XLEN-1:0]    FIntDivResultM;

    logic               BufFullE;
    logic               ResValid;
    logic               ResReady;
    logic               ResInt;
    logic [FMTBITS-1:0] ResFmt;
    logic [4:0]         ResRd;
    logic [NE+1:0]      ResUe;
    logic [DIVb:0]      ResUm;
    logic               ResSticky;
    logic [XLEN-1:0]    ResIntData;
    logic [1:0]         Count;
    logic               Overflow;

    modport master (
        output DoneM, FlushM, ClearQ, IntDivM, FmtM, RdM, UeM, UmM, DivStickyM,
               FIntDivResultM, ResReady,
        input  BufFullE, ResValid, ResInt, ResFmt, ResRd, ResUe, ResUm, ResSticky,
               ResIntData, Count, Overflow
    );

    modport slave (
        input  DoneM, FlushM, ClearQ, IntDivM, FmtM, RdM, UeM, UmM, DivStickyM,
               FIntDivResultM, ResReady,
        output BufFullE, ResValid, ResInt, ResFmt, ResRd, ResUe, ResUm, ResSticky,
               ResIntData, Count, Overflow
    );
endinterface

// File: rtl/fdivsqrt_result_buf.sv
// Two-entry in-order buffer holding finished divide/sqrt results until the
// rounder or integer writeback accepts them; asserts BufFullE to hold off new divides.
module fdivsqrt_result_buf #(
    parameter int NE      = 11,
    parameter int DIVb    = 64,
    parameter int XLEN    = 64,
    parameter int FMTBITS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    fdivsqrt_result_buf_if.slave   bus
);
    typedef struct packed {
        logic               intd;
        logic [FMTBITS-1:0] fmt;
        logic [4:0]         rd;
        logic [NE+1:0]      ue;
        logic [DIVb:0]      um;
        logic               sticky;
        logic [XLEN-1:0]    idata;
    } ent_t;

    ent_t       r_ent [2];
    logic       r_wp;
    logic       r_rp;
    logic [1:0] r_count;
    logic       r_ovf;

    logic w_valid, w_full, w_push, w_pop, w_acc;
    ent_t w_in, w_head;

    assign w_valid = (r_count != 2'd0);
    assign w_full  = (r_count == 2'd2);
    assign w_push  = bus.DoneM & ~bus.FlushM;
    assign w_pop   = w_valid & bus.ResReady;
    // When full, a push only fits if the head leaves in the same cycle.
    assign w_acc   = w_push & (~w_full | w_pop);

    always_comb begin
        w_in        = '0;
        w_in.intd   = bus.IntDivM;
        w_in.fmt    = bus.FmtM;
        w_in.rd     = bus.RdM;
        w_in.ue     = bus.UeM;
        w_in.um     = bus.UmM;
        w_in.sticky = bus.DivStickyM;
        w_in.idata  = bus.FIntDivResultM;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_count <= 2'd0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < 2; i++) r_ent[i] <= '0;
        end else if (bus.ClearQ) begin
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push & ~w_acc) r_ovf <= 1'b1;
            if (w_acc) begin
                r_ent[r_wp] <= w_in;
                r_wp        <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            case ({w_acc, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Data outputs read zero whenever nothing is presented.
    assign w_head = w_valid ? r_ent[r_rp] : '0;

    assign bus.ResValid   = w_valid;
    assign bus.BufFullE   = w_full;
    assign bus.Count      = r_count;
    assign bus.Overflow   = r_ovf;
    assign bus.ResInt     = w_head.intd;
    assign bus.ResFmt     = w_head.fmt;
    assign bus.ResRd      = w_head.rd;
    assign bus.ResUe      = w_head.ue;
    assign bus.ResUm      = w_head.um;
    assign bus.ResSticky  = w_head.sticky;
    assign bus.ResIntData = w_head.idata;
endmodule

// File: tb/tb_fdivsqrt_result_buf.sv
// Directed bench for fdivsqrt_result_buf: queue-based reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_fdivsqrt_result_buf;
    localparam int NE = 11, DIVb = 64, XLEN = 64, FMTBITS = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fdivsqrt_result_buf_if #(.NE(NE), .DIVb(DIVb), .XLEN(XLEN), .FMTBITS(FMTBITS)) bus ();

    fdivsqrt_result_buf #(.NE(NE), .DIVb(DIVb), .XLEN(XLEN), .FMTBITS(FMTBITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic               intd;
        logic [FMTBITS-1:0] fmt;
        logic [4:0]         rd;
        logic [NE+1:0]      ue;
        logic [DIVb:0]      um;
        logic               sticky;
        logic [XLEN-1:0]    idata;
    } res_t;

    res_t q[$];
    bit   m_ovf;
    bit   m_ok = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of at most two results, updated from the inputs seen at each edge.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_ovf = 0;
            m_ok  = 1;
        end else if (m_ok) begin
            if (bus.ClearQ) q.delete();
            else begin
                int  sz;
                bit  pu, po;
                res_t r;
                sz = q.size();
                pu = bus.DoneM && !bus.FlushM;
                po = (sz != 0) && bus.ResReady;
                r.intd = bus.IntDivM; r.fmt = bus.FmtM; r.rd = bus.RdM; r.ue = bus.UeM;
                r.um = bus.UmM; r.sticky = bus.DivStickyM; r.idata = bus.FIntDivResultM;
                if (po) void'(q.pop_front());
                if (pu) begin
                    if (sz < 2 || po) q.push_back(r);
                    else m_ovf = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            res_t h;
            bit v;
            v = (q.size() != 0);
            if (v) h = q[0];
            else begin
                h.intd = 0; h.fmt = 0; h.rd = 0; h.ue = 0; h.um = 0; h.sticky = 0; h.idata = 0;
            end
            check("Count",      128'(bus.Count),      128'(q.size()));
            check("ResValid",   128'(bus.ResValid),   128'(v));
            check("BufFullE",   128'(bus.BufFullE),   128'(q.size() == 2));
            check("Overflow",   128'(bus.Overflow),   128'(m_ovf));
            check("ResInt",     128'(bus.ResInt),     128'(h.intd));
            check("ResFmt",     128'(bus.ResFmt),     128'(h.fmt));
            check("ResRd",      128'(bus.ResRd),      128'(h.rd));
            check("ResUe",      128'(bus.ResUe),      128'(h.ue));
            check("ResUm",      128'(bus.ResUm),      128'(h.um));
            check("ResSticky",  128'(bus.ResSticky),  128'(h.sticky));
            check("ResIntData", 128'(bus.ResIntData), 128'(h.idata));
        end
    end

    task automatic idle_in();
        bus.DoneM = 0; bus.FlushM = 0; bus.ClearQ = 0; bus.IntDivM = 0; bus.FmtM = 0;
        bus.RdM = 0; bus.UeM = 0; bus.UmM = 0; bus.DivStickyM = 0; bus.FIntDivResultM = 0;
    endtask

    // Present a result bundle for one cycle (call right after a negedge).
    task automatic done(input bit isint, input logic [4:0] rd, input logic [NE+1:0] ue,
                        input logic [DIVb:0] um, input logic [XLEN-1:0] idata);
        bus.DoneM = 1; bus.IntDivM = isint; bus.RdM = rd; bus.UeM = ue; bus.UmM = um;
        bus.FIntDivResultM = idata; bus.FmtM = 2'd1; bus.DivStickyM = ~isint;
        @(negedge clk);
        idle_in();
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [DIVb:0] one_um;
        one_um = '0;
        one_um[DIVb] = 1'b1;
        idle_in();
        bus.ResReady = 0;
        reset = 1;
        cyc(2);
        reset = 0;
        check("rst Count",    128'(bus.Count), 128'd0);
        check("rst ResValid", 128'(bus.ResValid), 128'd0);
        check("rst Overflow", 128'(bus.Overflow), 128'd0);
        check("rst ResUm",    128'(bus.ResUm), 128'd0);

        // Single FP result, consumer ready
        bus.ResReady = 1;
        done(0, 5'd5, 13'h3FF, one_um, 64'd0);
        check("fp1 ResValid", 128'(bus.ResValid), 128'd1);
        check("fp1 ResUe",    128'(bus.ResUe), 128'h3FF);
        check("fp1 ResRd",    128'(bus.ResRd), 128'd5);
        cyc(1);
        check("fp1 drained",  128'(bus.Count), 128'd0);
        check("fp1 ResValid0", 128'(bus.ResValid), 128'd0);

        // Fill with back-pressure, then drain in order
        bus.ResReady = 0;
        done(1, 5'd1, 13'd0, '0, 64'h7);
        done(0, 5'd3, 13'h400, one_um, 64'd0);
        cyc(2);
        check("fill Count",   128'(bus.Count), 128'd2);
        check("fill Full",    128'(bus.BufFullE), 128'd1);
        check("fill head",    128'(bus.ResIntData), 128'h7);
        bus.ResReady = 1;
        cyc(1);
        check("pop2 Rd",      128'(bus.ResRd), 128'd3);
        check("pop2 Int",     128'(bus.ResInt), 128'd0);
        cyc(1);
        check("pop2 empty",   128'(bus.Count), 128'd0);

        // Full with simultaneous push and pop
        bus.ResReady = 0;
        done(1, 5'd10, 13'd0, '0, 64'hA);
        done(1, 5'd11, 13'd0, '0, 64'hB);
        bus.ResReady = 1;
        done(1, 5'd12, 13'd0, '0, 64'hC);
        bus.ResReady = 0;
        check("pp Count",     128'(bus.Count), 128'd2);
        check("pp Overflow",  128'(bus.Overflow), 128'd0);
        check("pp head",      128'(bus.ResIntData), 128'hB);
        bus.ResReady = 1;
        cyc(1);
        bus.ResReady = 0;
        check("pp next",      128'(bus.ResIntData), 128'hC);

        // Refill to full, then overflow
        done(1, 5'd13, 13'd0, '0, 64'hD);
        done(1, 5'd14, 13'd0, '0, 64'hE);
        check("ovf Overflow", 128'(bus.Overflow), 128'd1);
        check("ovf Count",    128'(bus.Count), 128'd2);
        check("ovf head",     128'(bus.ResIntData), 128'hC);
        bus.ClearQ = 1;
        cyc(1);
        bus.ClearQ = 0;
        check("clr Count",    128'(bus.Count), 128'd0);
        check("clr Ovf held", 128'(bus.Overflow), 128'd1);

        // Flush and clear-with-push
        done(0, 5'd20, 13'h3FE, one_um, 64'd0);
        bus.FlushM = 1;
        done(0, 5'd21, 13'h3FD, one_um, 64'd0);
        check("flush Count",  128'(bus.Count), 128'd1);
        check("flush head",   128'(bus.ResRd), 128'd20);
        bus.ClearQ = 1;
        done(1, 5'd22, 13'd0, '0, 64'h16);
        check("clrpush Count", 128'(bus.Count), 128'd0);
        check("clrpush Valid", 128'(bus.ResValid), 128'd0);
        check("clrpush Data",  128'(bus.ResIntData), 128'd0);

        // Only reset clears Overflow
        reset = 1;
        cyc(1);
        reset = 0;
        check("rst2 Overflow", 128'(bus.Overflow), 128'd0);
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fdivsqrt_result_buf.md
Name: fdivsqrt_result_buf

Overview:
- 2-entry result buffer directly downstream of the divide/square-root unit.
- Captures the M-stage result bundle (UeM, UmM, DivStickyM, FIntDivResultM plus tag fields) on the one-cycle done strobe.
- Presents entries in order to the FP rounder / integer writeback through a valid/ready handshake.
- Back-pressures the divider start logic when full, so a finished divide is never lost across pipeline stalls.

Parameters:
- NE, 11, exponent width of widest FP format; stored exponent is NE+2 bits.
- DIVb, 64, significand result MSB index; stored significand is DIVb+1 bits.
- XLEN, 64, integer result width.
- FMTBITS, 2, format tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- DoneM  in  1  one-cycle strobe: result bundle below is valid this cycle.
- FlushM  in  1  kill the result presented this cycle; no push.
- ClearQ  in  1  synchronous clear of all buffered entries.
- IntDivM  in  1  tag: 1 = integer div/rem result, 0 = FP result.
- FmtM  in  FMTBITS  tag: FP format.
- RdM  in  5  tag: destination register.
- UeM  in  NE+2  FP exponent result.
- UmM  in  DIVb+1  FP significand result.
- DivStickyM  in  1  FP sticky bit.
- FIntDivResultM  in  XLEN  integer result.
- BufFullE  out  1  both entries occupied; divider must not start.
- ResValid  out  1  head entry valid.
- ResReady  in  1  consumer accepts head entry.
- ResInt, ResFmt, ResRd, ResUe, ResUm, ResSticky, ResIntData  out  (1, FMTBITS, 5, NE+2, DIVb+1, 1, XLEN)  head entry fields.
- Count  out  2  occupancy, 0..2.
- Overflow  out  1  sticky error: a push was attempted while full.

Behaviour:
- Storage: two entries, 1-bit write pointer wp, 1-bit read pointer rp, 2-bit count.
- Definitions: push = DoneM & ~FlushM; pop = ResValid & ResReady.
- Reset: count=0, wp=rp=0, Overflow=0, all entry storage=0. All outputs are 0 in the first cycle after reset.
- Priority, highest first: reset > ClearQ > push/pop.
- ClearQ: count=0, wp=rp=0 next cycle. Same-cycle push and pop are ignored. Overflow is not cleared; only reset clears it.
- Push accepted when count<2, or when count==2 and pop is true in the same cycle. On accept: entry[wp] <= bundle, wp toggles.
- Push when count==2 without pop: bundle dropped, Overflow <= 1, state unchanged.
- Pop: rp toggles.
- Count next value: +1 on accepted push only, -1 on pop only, unchanged on both or neither.
- Pop with count==0 is impossible, because ResValid=0.
- Latency: DoneM in cycle N, ResValid=1 and head fields valid in cycle N+1. No combinational bypass from inputs to outputs.
- ResValid = (count!=0). When ResValid=0, all Res* data outputs are forced to 0.
- Head fields come from entry[rp] (registered storage, read mux only).
- Head fields are held stable while ResValid=1 and ResReady=0.
- Ordering: strict FIFO; integer and FP results share one queue.
- BufFullE = (count==2), combinational from state. It does not depend on same-cycle pop.
- FlushM with DoneM: no push, no other effect.
- Pointer wrap: 1-bit pointers wrap naturally; full/empty is decided by count, never by pointer comparison.

Test Plan:
- Reset then idle: reset held 2 cycles -> Count=0, ResValid=0, BufFullE=0, Overflow=0, all Res* = 0.
- Single FP result: DoneM with UeM=0x3FF, UmM=1<<DIVb, RdM=5, ResReady=1 -> next cycle ResValid=1, ResUe=0x3FF, ResRd=5. Following cycle Count=0 and ResValid=0.
- Fill and back-pressure: two DoneM pulses (int 0x7, then FP Rd=3) with ResReady=0 -> Count=2, BufFullE=1. Head stays int 0x7 until ResReady. Then pops occur in order 0x7, then Rd=3.
- Full with simultaneous push/pop: count=2, DoneM and ResReady both 1 -> Count stays 2, Overflow=0. New entry appears after the remaining old entry.
- Overflow: count=2, ResReady=0, DoneM=1 -> Overflow=1, Count=2, head unchanged. Overflow stays set after ClearQ, and clears only on reset.
- Flush/clear: DoneM with FlushM=1 -> Count unchanged. ClearQ with DoneM=1 at count=1 -> next cycle Count=0, ResValid=0.
